// File: rtl/bin2bcd_seq.sv
// bin2bcd_seq: sequential double-dabble binary-to-BCD converter with valid/ready handshakes.
// One shift-and-add-3 iteration per clock; result held in DONE until the consumer takes it.
module bin2bcd_seq #(
    parameter int BIN_W  = 8,
    parameter int DIGITS = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [BIN_W-1:0]      in_bin,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [4*DIGITS-1:0]   out_bcd
);
    localparam int BW = 4 * DIGITS;
    localparam int SW = BW + BIN_W;
    localparam int CW = (BIN_W > 2) ? $clog2(BIN_W) : 1;

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] SHIFT = 2'd1;
    localparam logic [1:0] DONE  = 2'd2;

    logic [1:0]    state_q, state_d;
    logic [SW-1:0] sr_q, sr_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [BW-1:0] out_q, out_d;
    logic [BW-1:0] adj;
    logic [SW-1:0] shifted;

    // Add-3 correction on every digit >= 5, then shift the whole register.
    always_comb begin
        adj = sr_q[SW-1:BIN_W];
        for (int i = 0; i < DIGITS; i++)
            adj[4*i +: 4] = (adj[4*i +: 4] >= 4'd5) ? adj[4*i +: 4] + 4'd3 : adj[4*i +: 4];
        shifted = {adj, sr_q[BIN_W-1:0]} << 1;
    end

    always_comb begin
        state_d = state_q;
        sr_d    = sr_q;
        cnt_d   = cnt_q;
        out_d   = out_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    sr_d    = {{BW{1'b0}}, in_bin};
                    cnt_d   = '0;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                sr_d  = shifted;
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CW'(BIN_W - 1)) begin
                    out_d   = shifted[SW-1:BIN_W];
                    state_d = DONE;
                end
            end
            DONE:    state_d = out_ready ? IDLE : DONE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            sr_q    <= '0;
            cnt_q   <= '0;
            out_q   <= '0;
        end else begin
            state_q <= state_d;
            sr_q    <= sr_d;
            cnt_q   <= cnt_d;
            out_q   <= out_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign out_bcd   = out_q;
endmodule

// File: tb/tb_bin2bcd_seq.sv
// tb_bin2bcd_seq: directed self-checking bench for bin2bcd_seq (BIN_W=8, DIGITS=3).
module tb_bin2bcd_seq;
    logic        clk = 0;
    logic        rst = 1;
    logic        in_valid = 0;
    logic        in_ready;
    logic [7:0]  in_bin = '0;
    logic        out_valid;
    logic        out_ready = 0;
    logic [11:0] out_bcd;
    int          errors = 0;
    int          checks = 0;
    int          cyc = 0;

    bin2bcd_seq #(.BIN_W(8), .DIGITS(3)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_bin(in_bin),
        .out_valid(out_valid), .out_ready(out_ready), .out_bcd(out_bcd)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [11:0] ref_bcd(input int v);
        return {4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Accept v on the next edge, then count edges until out_valid (bounded).
    task automatic convert(input logic [7:0] v, output int lat);
        int n;
        n = 0;
        while (!in_ready && n < 50) begin step(); n++; end
        in_valid = 1;
        in_bin   = v;
        step();
        in_valid = 0;
        lat = 0;
        while (!out_valid && lat < 50) begin step(); lat++; end
    endtask

    initial begin
        int lat, acc, prev, n;
        #12;
        chk("reset_in_ready", in_ready, 1);
        chk("reset_out_valid", out_valid, 0);
        chk("reset_out_bcd", out_bcd, 0);
        rst = 0;
        step();

        convert(8'd0, lat);
        chk("lat_0", lat, 8);
        chk("bcd_0", out_bcd, 12'h000);
        out_ready = 1; step(); out_ready = 0;

        convert(8'd255, lat);
        chk("bcd_255", out_bcd, 12'h255);
        out_ready = 1; step(); out_ready = 0;
        convert(8'd99, lat);
        chk("bcd_99", out_bcd, 12'h099);
        out_ready = 1; step(); out_ready = 0;
        convert(8'd100, lat);
        chk("bcd_100", out_bcd, 12'h100);
        out_ready = 1; step(); out_ready = 0;

        convert(8'd42, lat);
        for (int i = 0; i < 5; i++) begin
            step();
            chk("hold_valid", out_valid, 1);
            chk("hold_bcd", out_bcd, 12'h042);
            chk("hold_in_ready", in_ready, 0);
        end
        out_ready = 1; step(); out_ready = 0;
        chk("release_valid", out_valid, 0);
        chk("release_in_ready", in_ready, 1);

        in_valid = 1; in_bin = 8'd123; step();
        for (int i = 0; i < 4; i++) begin
            in_valid = i[0]; in_bin = 8'd55; step();
        end
        in_valid = 0;
        lat = 4;
        while (!out_valid && lat < 50) begin step(); lat++; end
        chk("busy_lat", lat, 8);
        chk("busy_ignored", out_bcd, 12'h123);
        out_ready = 1; step(); out_ready = 0;

        in_valid = 1; in_bin = 8'd200; step(); in_valid = 0;
        for (int i = 0; i < 4; i++) step();
        rst = 1;
        #1;
        chk("midrst_in_ready", in_ready, 1);
        chk("midrst_out_valid", out_valid, 0);
        chk("midrst_out_bcd", out_bcd, 0);
        step();
        rst = 0;
        step();
        convert(8'd7, lat);
        chk("after_rst_lat", lat, 8);
        chk("after_rst_bcd", out_bcd, 12'h007);

        out_ready = 1;
        prev = 0;
        for (int v = 0; v < 256; v++) begin
            in_valid = 1;
            in_bin = 8'(v);
            n = 0;
            while (!in_ready && n < 50) begin step(); n++; end
            step();
            in_valid = 0;
            acc = cyc;
            if (v > 0) chk("interval", acc - prev, 10);
            prev = acc;
            n = 0;
            while (!out_valid && n < 50) begin step(); n++; end
            chk($sformatf("exh_%0d", v), out_bcd, ref_bcd(v));
        end
        out_ready = 0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
